// File: rtl/ft245_sync_bus_scheduler.sv
// FT245 synchronous FIFO bus scheduler: round-robin read/write bursts
// with a one-cycle output-enable lead-in and fixed bus turnaround.
module ft245_sync_bus_scheduler #(
    parameter int RD_BURST_MAX = 512,
    parameter int WR_BURST_MAX = 512,
    parameter int TURN_CYCLES  = 1
) (
    input  logic ft245_dclk,
    input  logic rst,
    input  logic ft245_rxfn,
    input  logic ft245_txen,
    input  logic tx_pending,
    input  logic rx_ready,
    output logic ft245_oen,
    output logic ft245_rdn,
    output logic ft245_wrn,
    output logic data_oe,
    output logic rd_xfer,
    output logic wr_xfer,
    output logic busy
);

    localparam int BMAX = (RD_BURST_MAX > WR_BURST_MAX) ? RD_BURST_MAX : WR_BURST_MAX;
    localparam int CW   = $clog2(BMAX + 1);
    localparam int TW   = $clog2(TURN_CYCLES + 1);

    localparam logic [CW-1:0] RD_LAST   = CW'(RD_BURST_MAX - 1);
    localparam logic [CW-1:0] WR_LAST   = CW'(WR_BURST_MAX - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_OE = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_burst_cnt;
    logic [TW-1:0]   r_turn_cnt;
    logic            r_last_wr;

    logic w_rd_req;
    logic w_wr_req;
    logic w_oen;
    logic w_rdn;
    logic w_wrn;
    logic w_data_oe;
    logic w_rd_xfer;
    logic w_wr_xfer;

    assign w_rd_req = ~ft245_rxfn & rx_ready;
    assign w_wr_req = ~ft245_txen & tx_pending;

    always_comb begin
        w_next    = r_state;
        w_oen     = 1'b1;
        w_rdn     = 1'b1;
        w_wrn     = 1'b1;
        w_data_oe = 1'b0;
        w_rd_xfer = 1'b0;
        w_wr_xfer = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On a tie, grant the direction not served last
                if (w_rd_req && (!w_wr_req || r_last_wr)) begin
                    w_next = RD_OE;
                end else if (w_wr_req) begin
                    w_next = WR;
                end
            end
            RD_OE: begin
                w_oen  = 1'b0;
                w_next = RD;
            end
            RD: begin
                w_oen     = 1'b0;
                w_rdn     = ~w_rd_req;
                w_rd_xfer = w_rd_req;
                if (!w_rd_req || (r_burst_cnt == RD_LAST)) begin
                    w_next = TURN;
                end
            end
            WR: begin
                w_data_oe = 1'b1;
                w_wrn     = ~w_wr_req;
                w_wr_xfer = w_wr_req;
                if (!w_wr_req || (r_burst_cnt == WR_LAST)) begin
                    w_next = TURN;
                end
            end
            TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ft245_dclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_turn_cnt  <= '0;
            r_last_wr   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == RD_OE) begin
                r_last_wr   <= 1'b0;
                r_burst_cnt <= '0;
            end else if (r_state == IDLE && w_next == WR) begin
                r_last_wr   <= 1'b1;
                r_burst_cnt <= '0;
            end else if (w_rd_xfer || w_wr_xfer) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (r_state == TURN) begin
                r_turn_cnt <= (r_turn_cnt == TURN_LAST) ? '0 : r_turn_cnt + 1'b1;
            end
        end
    end

    assign ft245_oen = w_oen;
    assign ft245_rdn = w_rdn;
    assign ft245_wrn = w_wrn;
    assign data_oe   = w_data_oe;
    assign rd_xfer   = w_rd_xfer;
    assign wr_xfer   = w_wr_xfer;
    assign busy      = (r_state != IDLE);

endmodule
